// File: rtl/ps2_command_parser.sv
// Line editor and command decoder for the PS/2 ASCII stream.
// It collects a line, publishes a snapshot on Enter, parses A/V/F/R commands and drives angle/velocity/fire.
module ps2_command_parser #(
  parameter int LINE_CHARS = 32,
  parameter int ANGLE_MAX  = 180,
  parameter int VEL_MAX    = 100,
  parameter int FIRE_HOLD  = 50000000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic [8*LINE_CHARS-1:0] line_content,
  output logic                    line_ready,
  output logic [31:0]             angle,
  output logic [31:0]             velocity,
  output logic                    fire,
  output logic                    sys_reset,
  output logic                    cmd_error
);
  localparam int CW = $clog2(LINE_CHARS + 1);
  localparam int IW = $clog2(LINE_CHARS);
  localparam int FW = $clog2(FIRE_HOLD + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(LINE_CHARS);
  localparam logic [19:0]   ANGLE_LIM  = 20'(ANGLE_MAX);
  localparam logic [19:0]   VEL_LIM    = 20'(VEL_MAX);
  localparam logic [FW-1:0] FIRE_LOAD  = FW'(FIRE_HOLD);

  typedef enum logic [1:0] {COLLECT, PARSE, APPLY} state_e;
  typedef enum logic [2:0] {OP_NONE, OP_A, OP_V, OP_F, OP_R} op_e;
  typedef enum logic [1:0] {PH_SKIP, PH_DIGITS, PH_TRAIL} phase_e;

  state_e                     state_q, state_d;
  op_e                        op_q, op_d;
  phase_e                     phase_q, phase_d;
  logic [LINE_CHARS-1:0][7:0] text_q, text_d, line_q, line_d;
  logic [CW-1:0]              count_q, count_d, idx_q, idx_d;
  logic                       overflow_q, overflow_d, err_q, err_d;
  logic [15:0]                acc_q, acc_d, angle_q, angle_d, velocity_q, velocity_d;
  logic [FW-1:0]              fire_cnt_q, fire_cnt_d;
  logic                       fire_q, fire_d, line_ready_q, line_ready_d;
  logic                       sys_reset_q, sys_reset_d, cmd_error_q, cmd_error_d;

  logic [7:0]  scan_ch;
  logic        is_digit, is_space;
  logic [19:0] acc_ext, lim;

  always_comb begin
    scan_ch  = text_q[idx_q[IW-1:0]];
    is_digit = (scan_ch >= 8'h30) && (scan_ch <= 8'h39);
    is_space = (scan_ch == 8'h20);
    lim      = (op_q == OP_A) ? ANGLE_LIM : VEL_LIM;
    acc_ext  = 20'(acc_q) * 20'd10 + 20'(scan_ch[3:0]);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    op_d         = op_q;
    phase_d      = phase_q;
    text_d       = text_q;
    line_d       = line_q;
    count_d      = count_q;
    idx_d        = idx_q;
    overflow_d   = overflow_q;
    err_d        = err_q;
    acc_d        = acc_q;
    angle_d      = angle_q;
    velocity_d   = velocity_q;
    line_ready_d = 1'b0;
    sys_reset_d  = 1'b0;
    cmd_error_d  = 1'b0;
    fire_cnt_d   = (fire_cnt_q != '0) ? fire_cnt_q - FW'(1) : fire_cnt_q;

    case (state_q)
      COLLECT: begin
        if (char_valid) begin
          if (char_in == 8'h0D) begin
            state_d = PARSE;
            idx_d   = '0;
            op_d    = OP_NONE;
            phase_d = PH_SKIP;
            acc_d   = '0;
            err_d   = overflow_q;
          end else if (char_in == 8'h08) begin
            if (count_q != '0) begin
              text_d[IW'(count_q - CW'(1))] = 8'h00;
              count_d = count_q - CW'(1);
            end
          end else if ((char_in >= 8'h20) && (char_in <= 8'h7E)) begin
            if (count_q < COUNT_FULL) begin
              text_d[count_q[IW-1:0]] = char_in;
              count_d = count_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      PARSE: begin
        // The first PARSE cycle publishes the snapshot, whatever the line length.
        if (idx_q == '0) begin
          line_ready_d = 1'b1;
          line_d       = text_q;
        end
        if (idx_q == count_q) begin
          state_d = APPLY;
          if (((op_q == OP_A) || (op_q == OP_V)) && (phase_q == PH_SKIP)) err_d = 1'b1;
        end else begin
          idx_d = idx_q + CW'(1);
          if (idx_q == '0) begin
            case (scan_ch)
              8'h41, 8'h61: begin op_d = OP_A; phase_d = PH_SKIP;  end
              8'h56, 8'h76: begin op_d = OP_V; phase_d = PH_SKIP;  end
              8'h46, 8'h66: begin op_d = OP_F; phase_d = PH_TRAIL; end
              8'h52, 8'h72: begin op_d = OP_R; phase_d = PH_TRAIL; end
              default:      err_d = 1'b1;
            endcase
          end else begin
            case (phase_q)
              PH_SKIP, PH_DIGITS: begin
                if (is_digit) begin
                  phase_d = PH_DIGITS;
                  acc_d   = acc_ext[15:0];
                  if (acc_ext > lim) err_d = 1'b1;
                end else if (is_space) begin
                  if (phase_q == PH_DIGITS) phase_d = PH_TRAIL;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: if (!is_space) err_d = 1'b1;
            endcase
          end
        end
      end

      APPLY: begin
        if (count_q != '0) begin
          if (err_q) begin
            cmd_error_d = 1'b1;
          end else begin
            case (op_q)
              OP_A:    angle_d    = acc_q;
              OP_V:    velocity_d = acc_q;
              OP_F:    if (!fire_q) fire_cnt_d = FIRE_LOAD;
              OP_R:    sys_reset_d = 1'b1;
              default: ;
            endcase
          end
        end
        text_d     = '0;
        count_d    = '0;
        overflow_d = 1'b0;
        state_d    = COLLECT;
      end

      default: state_d = COLLECT;
    endcase

    fire_d = (fire_cnt_d != '0);
  end

  // NOTE: state uses non-blocking assignments; the line buffer is reset too because its zero fill is visible in the snapshot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= COLLECT;
      op_q         <= OP_NONE;
      phase_q      <= PH_SKIP;
      text_q       <= '0;
      line_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
      err_q        <= 1'b0;
      acc_q        <= '0;
      angle_q      <= '0;
      velocity_q   <= '0;
      fire_cnt_q   <= '0;
      fire_q       <= 1'b0;
      line_ready_q <= 1'b0;
      sys_reset_q  <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      phase_q      <= phase_d;
      text_q       <= text_d;
      line_q       <= line_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      overflow_q   <= overflow_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
      angle_q      <= angle_d;
      velocity_q   <= velocity_d;
      fire_cnt_q   <= fire_cnt_d;
      fire_q       <= fire_d;
      line_ready_q <= line_ready_d;
      sys_reset_q  <= sys_reset_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign line_content = line_q;
  assign line_ready   = line_ready_q;
  assign angle        = 32'(angle_q);
  assign velocity     = 32'(velocity_q);
  assign fire         = fire_q;
  assign sys_reset    = sys_reset_q;
  assign cmd_error    = cmd_error_q;
endmodule

// File: tb/tb_ps2_command_parser.sv
// Randomized bench for ps2_command_parser: a queue-based line model predicts every output on every cycle.
module tb_ps2_command_parser;
  localparam int LC   = 8;
  localparam int AMAX = 180;
  localparam int VMAX = 100;
  localparam int FH   = 10;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [7:0]      char_in = 8'h00;
  logic            char_valid = 1'b0;
  logic [8*LC-1:0] line_content;
  logic            line_ready;
  logic [31:0]     angle, velocity;
  logic            fire, sys_reset, cmd_error;

  ps2_command_parser #(
    .LINE_CHARS(LC), .ANGLE_MAX(AMAX), .VEL_MAX(VMAX), .FIRE_HOLD(FH)
  ) dut (
    .clock(clock), .resetn(resetn), .char_in(char_in), .char_valid(char_valid),
    .line_content(line_content), .line_ready(line_ready), .angle(angle),
    .velocity(velocity), .fire(fire), .sys_reset(sys_reset), .cmd_error(cmd_error)
  );

  always #5 clock = ~clock;

  typedef enum int {R_NONE, R_ERR, R_A, R_V, R_F, R_R} res_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  byte unsigned    buf_q[$];
  byte unsigned    line_q[$];
  bit              ovf;
  logic [8*LC-1:0] exp_line, pend_line;
  int              exp_angle, exp_vel, fire_start, fire_until;
  int              enter_edge, ready_edge, apply_edge, pend_val;
  res_e            pend_res;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Command semantics on a finished line: trim, split off the opcode, validate the argument.
  function automatic void parse_line(input byte unsigned l[$], input bit of,
                                     output res_e r, output int v);
    byte unsigned rest[$];
    byte unsigned op;
    int lim;
    v = 0;
    r = R_ERR;
    if (of) return;
    if (l.size() == 0) begin r = R_NONE; return; end
    op = l[0];
    if (op >= 8'h61 && op <= 8'h7A) op = op - 8'd32;
    for (int i = 1; i < l.size(); i++) rest.push_back(l[i]);
    while (rest.size() > 0 && rest[rest.size()-1] == 8'h20) void'(rest.pop_back());
    if (op == 8'h46 || op == 8'h52) begin
      if (rest.size() == 0) r = (op == 8'h46) ? R_F : R_R;
      return;
    end
    if (op != 8'h41 && op != 8'h56) return;
    lim = (op == 8'h41) ? AMAX : VMAX;
    while (rest.size() > 0 && rest[0] == 8'h20) void'(rest.pop_front());
    if (rest.size() == 0) return;
    foreach (rest[i]) begin
      if (rest[i] < 8'h30 || rest[i] > 8'h39) return;
      v = v * 10 + (rest[i] - 8'h30);
      if (v > lim) return;
    end
    r = (op == 8'h41) ? R_A : R_V;
  endfunction

  function automatic bit fire_at(int e);
    return (e >= fire_start) && (e < fire_until);
  endfunction

  task automatic model_reset();
    buf_q.delete();
    ovf        = 1'b0;
    exp_line   = '0;
    pend_line  = '0;
    exp_angle  = 0;
    exp_vel    = 0;
    fire_start = 0;
    fire_until = 0;
    enter_edge = -100;
    ready_edge = -100;
    apply_edge = -100;
    pend_res   = R_NONE;
    pend_val   = 0;
  endtask

  // Advance one clock, update the model for that edge and compare every output.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (cyc == ready_edge) exp_line = pend_line;
    if (cyc == apply_edge) begin
      case (pend_res)
        R_A: exp_angle = pend_val;
        R_V: exp_vel   = pend_val;
        R_F: if (!fire_at(cyc - 1)) begin fire_start = cyc; fire_until = cyc + FH; end
        default: ;
      endcase
    end
    check("line_ready",   line_ready,   cyc == ready_edge);
    check("line_content", line_content, exp_line);
    check("angle",        angle,        32'(exp_angle));
    check("velocity",     velocity,     32'(exp_vel));
    check("fire",         fire,         fire_at(cyc));
    check("sys_reset",    sys_reset,    (cyc == apply_edge) && (pend_res == R_R));
    check("cmd_error",    cmd_error,    (cyc == apply_edge) && (pend_res == R_ERR));
  endtask

  task automatic accept(byte unsigned c, int e);
    if (e > enter_edge && e <= apply_edge) return;
    if (c == 8'h0D) begin
      pend_line = '0;
      foreach (buf_q[i]) pend_line[8*i +: 8] = buf_q[i];
      parse_line(buf_q, ovf, pend_res, pend_val);
      enter_edge = e;
      ready_edge = e + 1;
      apply_edge = e + buf_q.size() + 2;
      buf_q.delete();
      ovf = 1'b0;
    end else if (c == 8'h08) begin
      if (buf_q.size() > 0) void'(buf_q.pop_back());
    end else if (c >= 8'h20 && c <= 8'h7E) begin
      if (buf_q.size() < LC) buf_q.push_back(c);
      else ovf = 1'b1;
    end
  endtask

  task automatic send(byte unsigned c);
    accept(c, cyc + 1);
    char_in    = c;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic type_bytes(byte unsigned q[$], int gap_max);
    foreach (q[i]) begin
      send(q[i]);
      idle($urandom_range(0, gap_max));
    end
    send(8'h0D);
  endtask

  task automatic type_line(string s, int gap_max);
    byte unsigned q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    type_bytes(q, gap_max);
  endtask

  task automatic wait_done();
    if (apply_edge > cyc) idle(apply_edge - cyc);
    idle(1);
  endtask

  task automatic gen_line();
    string ops;
    string num;
    int mode;
    ops  = "AaVvFfRrQ ";
    mode = $urandom_range(0, 11);
    line_q.delete();
    if (mode == 0) begin
      repeat ($urandom_range(6, 12)) line_q.push_back(8'($urandom_range(32, 126)));
    end else begin
      line_q.push_back(ops[$urandom_range(0, 9)]);
      repeat ($urandom_range(0, 2)) line_q.push_back(8'h20);
      if (mode < 9) begin
        num = $sformatf("%0d", $urandom_range(0, 260));
        if (mode == 1) line_q.push_back(8'h30);
        for (int i = 0; i < num.len(); i++) line_q.push_back(num[i]);
      end
      repeat ($urandom_range(0, 2)) line_q.push_back(8'h20);
      if (mode == 10)
        line_q.insert($urandom_range(0, line_q.size()), 8'($urandom_range(32, 126)));
      if (mode == 11) begin
        line_q.insert($urandom_range(0, line_q.size()), 8'h08);
        line_q.insert($urandom_range(0, line_q.size()), 8'h7F);
        line_q.insert($urandom_range(0, line_q.size()), 8'h01);
      end
    end
  endtask

  initial begin
    byte unsigned bq[$];
    model_reset();
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(2);

    type_line("A45", 0);
    wait_done();
    check("a45_angle", angle, 32'd45);
    check("a45_snapshot", line_content, 64'h0000_0000_0035_3441);

    type_line("V60", 0);      wait_done();
    type_line("v 1x0", 0);    wait_done();
    check("v1x0_velocity", velocity, 32'd60);
    type_line("V 100  ", 0);  wait_done();
    check("v100_velocity", velocity, 32'd100);
    type_line("V101", 0);     wait_done();
    check("v101_velocity", velocity, 32'd100);

    type_line("F", 0);        wait_done();
    type_line("F", 0);        wait_done();
    check("fire_still_high", fire, 1'b1);
    idle(FH);
    check("fire_dropped", fire, 1'b0);

    bq = '{8'h41, 8'h39, 8'h08, 8'h37};
    type_bytes(bq, 0);        wait_done();
    check("backspace_angle", angle, 32'd7);
    send(8'h08);
    type_line("A8", 0);       wait_done();
    check("empty_bs_angle", angle, 32'd8);

    type_line("A1234567X", 0); wait_done();
    check("overflow_snapshot", line_content, 64'h3736_3534_3332_3141);
    check("overflow_angle", angle, 32'd8);
    type_line("A12", 0);      wait_done();
    check("after_overflow_angle", angle, 32'd12);

    type_line("R", 0);        wait_done();
    check("r_angle", angle, 32'd12);
    type_line("", 0);         wait_done();

    type_line("A90", 0);
    idle(2);
    resetn = 1'b0;
    #1;
    check("abort_angle", angle, 32'd0);
    check("abort_line", line_content, '0);
    check("abort_velocity", velocity, 32'd0);
    model_reset();
    idle(2);
    resetn = 1'b1;
    idle(6);
    check("abort_no_apply", angle, 32'd0);

    for (int n = 0; n < 200; n++) begin
      gen_line();
      type_bytes(line_q, $urandom_range(0, 1));
      idle($urandom_range(0, 12));
    end
    wait_done();
    idle(FH + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
